// File: rtl/satd_pkg.sv
// Shared widths, state encoding and lane helper for the SATD datapath.
package satd_pkg;

  localparam int DIFF_W = 9;
  localparam int ROW_W  = DIFF_W + 3;
  localparam int COL_W  = ROW_W + 3;
  localparam int SATD_W = 20;

  typedef enum logic [1:0] {
    ROW  = 2'd0,
    COL  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Lane k of a packed row of 8 signed differences (lane 0 in the LSBs).
  function automatic logic signed [DIFF_W-1:0] diff_lane(input logic [8*DIFF_W-1:0] row,
                                                         input logic [2:0] k);
    return row[k*DIFF_W +: DIFF_W];
  endfunction

endpackage

// File: rtl/hadamard_satd_8x8_hadamard8.sv
// Combinational 8-point Hadamard transform, Sylvester natural order, no scaling.
// Each of the 3 butterfly stages is sign-extended to the full output width.
module hadamard8 #(
  parameter int IW = 9
) (
  input  logic [8*IW-1:0]     x,
  output logic [8*(IW+3)-1:0] y
);

  localparam int OW = IW + 3;

  logic signed [OW-1:0] s0_s [8];
  logic signed [OW-1:0] s1_s [8];
  logic signed [OW-1:0] s2_s [8];
  logic signed [OW-1:0] s3_s [8];

  // Three butterfly stages with strides 4, 2 and 1.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      s0_s[i] = {{3{x[i*IW+IW-1]}}, x[i*IW +: IW]};
    end
    for (int j = 0; j < 4; j++) begin
      s1_s[j]   = s0_s[j] + s0_s[j+4];
      s1_s[j+4] = s0_s[j] - s0_s[j+4];
    end
    for (int j = 0; j < 4; j++) begin
      s2_s[(j/2)*4 + (j%2)]     = s1_s[(j/2)*4 + (j%2)] + s1_s[(j/2)*4 + (j%2) + 2];
      s2_s[(j/2)*4 + (j%2) + 2] = s1_s[(j/2)*4 + (j%2)] - s1_s[(j/2)*4 + (j%2) + 2];
    end
    for (int j = 0; j < 4; j++) begin
      s3_s[2*j]   = s2_s[2*j] + s2_s[2*j+1];
      s3_s[2*j+1] = s2_s[2*j] - s2_s[2*j+1];
    end
    for (int i = 0; i < 8; i++) begin
      y[i*OW +: OW] = s3_s[i];
    end
  end

endmodule

// File: rtl/hadamard_satd_8x8.sv
// 8x8 Hadamard SATD: row transform on entry into a transpose buffer, then one
// column transform per cycle with |coef| accumulation, one result per block.
module hadamard_satd_8x8
  import satd_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*DIFF_W-1:0] diff_row,
  output logic                out_valid,
  output logic [SATD_W-1:0]   out_satd
);

  state_e              state_r;
  logic [2:0]          row_cnt_r;
  logic [2:0]          col_cnt_r;
  logic [SATD_W-1:0]   acc_r;
  logic                in_ready_r;
  logic                out_valid_r;
  logic [SATD_W-1:0]   out_satd_r;
  logic [ROW_W-1:0]    buf_r [8][8];

  logic [8*ROW_W-1:0]  row_coef_s;
  logic [8*ROW_W-1:0]  col_in_s;
  logic [8*COL_W-1:0]  col_coef_s;
  logic [COL_W-1:0]    mag_s [8];
  logic [SATD_W-1:0]   col_sum_s;
  logic                row_acc_s;

  assign row_acc_s = in_valid && in_ready_r;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_satd  = out_satd_r;

  hadamard8 #(.IW(DIFF_W)) u_row_xform (
    .x (diff_row),
    .y (row_coef_s)
  );

  hadamard8 #(.IW(ROW_W)) u_col_xform (
    .x (col_in_s),
    .y (col_coef_s)
  );

  // Transpose-buffer write: accepted row r lands in buffer row r.
  always_ff @(posedge clk) begin
    if (row_acc_s) begin
      for (int i = 0; i < 8; i++) begin
        buf_r[row_cnt_r][i] <= row_coef_s[i*ROW_W +: ROW_W];
      end
    end
  end

  // Column read mux: element i of the column is buffer row i, column c.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      col_in_s[i*ROW_W +: ROW_W] = buf_r[i][col_cnt_r];
    end
  end

  // Magnitudes of the 8 column coefficients; the most negative value cannot occur.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      if (col_coef_s[i*COL_W + COL_W - 1]) begin
        mag_s[i] = ~col_coef_s[i*COL_W +: COL_W] + {{(COL_W-1){1'b0}}, 1'b1};
      end else begin
        mag_s[i] = col_coef_s[i*COL_W +: COL_W];
      end
    end
  end

  // Per-column sum of magnitudes.
  always_comb begin
    col_sum_s = {SATD_W{1'b0}};
    for (int i = 0; i < 8; i++) begin
      col_sum_s = col_sum_s + {{(SATD_W-COL_W){1'b0}}, mag_s[i]};
    end
  end

  // Control FSM: ROW collects 8 rows, COL accumulates 8 columns, DONE emits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ROW;
      row_cnt_r   <= 3'd0;
      col_cnt_r   <= 3'd0;
      acc_r       <= {SATD_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_satd_r  <= {SATD_W{1'b0}};
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        ROW: begin
          if (row_acc_s) begin
            row_cnt_r <= row_cnt_r + 3'd1;
            if (row_cnt_r == 3'd7) begin
              state_r    <= COL;
              in_ready_r <= 1'b0;
            end
          end
        end
        COL: begin
          acc_r     <= acc_r + col_sum_s;
          col_cnt_r <= col_cnt_r + 3'd1;
          if (col_cnt_r == 3'd7) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          out_satd_r  <= acc_r;
          out_valid_r <= 1'b1;
          acc_r       <= {SATD_W{1'b0}};
          state_r     <= ROW;
          in_ready_r  <= 1'b1;
        end
        default: begin
          state_r    <= ROW;
          row_cnt_r  <= 3'd0;
          col_cnt_r  <= 3'd0;
          acc_r      <= {SATD_W{1'b0}};
          in_ready_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hadamard_satd_8x8.sv
// Self-checking bench for hadamard_satd_8x8: directed table, flow control,
// reset aborts and random blocks against a direct-formula SATD model.
module tb_hadamard_satd_8x8;
  import satd_pkg::*;

  typedef logic [64*DIFF_W-1:0] blk_t;
  typedef struct packed {
    blk_t              blk;
    logic [SATD_W-1:0] exp;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [8*DIFF_W-1:0] diff_row;
  logic                out_valid;
  logic [SATD_W-1:0]   out_satd;

  int total = 0;
  int bad = 0;
  int ov_count = 0;

  always #5 clk = ~clk;

  hadamard_satd_8x8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff_row  (diff_row),
    .out_valid (out_valid),
    .out_satd  (out_satd)
  );

  always @(negedge clk) begin
    if (out_valid) ov_count <= ov_count + 1;
  end

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic blk_t set_d(input blk_t b, input int r, input int c, input int v);
    logic [31:0] t;
    t = v;
    b[(r*8+c)*DIFF_W +: DIFF_W] = t[DIFF_W-1:0];
    return b;
  endfunction

  // SATD straight from the definition: sum over (u,v) of |sum d[r][c]*H[u][r]*H[v][c]|.
  function automatic int ref_satd(input blk_t b);
    int d [8][8];
    int s, tot;
    logic [2:0] u3, v3, r3, c3;
    tot = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        d[r][c] = diff_lane(b[r*8*DIFF_W +: 8*DIFF_W], 3'(c));
    for (int u = 0; u < 8; u++) begin
      for (int v = 0; v < 8; v++) begin
        s = 0;
        u3 = 3'(u); v3 = 3'(v);
        for (int r = 0; r < 8; r++) begin
          for (int c = 0; c < 8; c++) begin
            r3 = 3'(r); c3 = 3'(c);
            if ((($countones(u3 & r3) + $countones(v3 & c3)) % 2) == 1) s -= d[r][c];
            else s += d[r][c];
          end
        end
        tot += (s < 0) ? -s : s;
      end
    end
    return tot;
  endfunction

  function automatic blk_t rand_blk();
    blk_t b = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b = set_d(b, r, c, int'($urandom_range(510)) - 255);
    return b;
  endfunction

  // Offer one row until accepted (bounded); returns at accept edge + #1.
  task automatic send_row(input logic [8*DIFF_W-1:0] row, input int gaps);
    int w;
    for (int g = 0; g < gaps; g++) begin
      in_valid = 1'b0;
      diff_row = 8*DIFF_W'($urandom());
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    diff_row = row;
    w = 0;
    while (!in_ready && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 40) chk("row_accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Full block with timing checks; junk keeps in_valid high with garbage while busy.
  task automatic run_block(input blk_t b, input int gap_max, input bit junk,
                           input int exp, input string name);
    int low, start;
    start = ov_count;
    for (int r = 0; r < 8; r++)
      send_row(b[r*8*DIFF_W +: 8*DIFF_W], int'($urandom_range(gap_max)));
    low = 0;
    while (!in_ready && low < 20) begin
      in_valid = junk;
      diff_row = 8*DIFF_W'($urandom());
      low++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk({name, "_busy_cycles"}, low, 9);
    chk({name, "_valid_e9"}, out_valid, 1);
    chk({name, "_satd"}, out_satd, exp);
    @(posedge clk); #1;
    chk({name, "_valid_e10"}, out_valid, 0);
    chk({name, "_satd_hold"}, out_satd, exp);
    chk({name, "_pulses"}, ov_count - start, 1);
  endtask

  vec_t  tbl [5];
  string tname [5];

  initial begin
    blk_t b, ba, bb;
    int start;

    b = '0;
    tbl[0] = '{blk: b, exp: 20'd0};     tname[0] = "zeros";
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) b = set_d(b, r, c, 1);
    tbl[1] = '{blk: b, exp: 20'd64};    tname[1] = "ones";
    b = set_d('0, 0, 0, -255);
    tbl[2] = '{blk: b, exp: 20'd16320}; tname[2] = "impulse";
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) b = set_d(b, r, c, 255);
    tbl[3] = '{blk: b, exp: 20'd16320}; tname[3] = "all255";
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) b = set_d(b, r, c, ((r + c) % 2 == 1) ? -100 : 100);
    tbl[4] = '{blk: b, exp: 20'd6400};  tname[4] = "checker";

    rst = 1'b1; in_valid = 1'b0; diff_row = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_satd", out_satd, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      chk({tname[i], "_model"}, ref_satd(tbl[i].blk), tbl[i].exp);
      run_block(tbl[i].blk, 0, 1'b0, int'(tbl[i].exp), tname[i]);
    end

    // Flow control: random gaps and junk offered while busy.
    run_block(tbl[1].blk, 3, 1'b1, 64, "flow");

    // Reset after 4 rows of A, then full B gives one result for B only.
    ba = rand_blk();
    bb = rand_blk();
    start = ov_count;
    for (int r = 0; r < 4; r++) send_row(ba[r*8*DIFF_W +: 8*DIFF_W], 0);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    chk("rst_row_ready", in_ready, 1);
    run_block(bb, 0, 1'b0, ref_satd(bb), "rst_row_b");
    chk("rst_row_total_pulses", ov_count - start, 1);

    // Reset during column phase: no result, block accepted afterwards.
    start = ov_count;
    for (int r = 0; r < 8; r++) send_row(ba[r*8*DIFF_W +: 8*DIFF_W], 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    chk("rst_col_ready", in_ready, 1);
    repeat (12) @(posedge clk);
    #1;
    chk("rst_col_no_pulse", ov_count - start, 0);
    run_block(tbl[4].blk, 0, 1'b0, 6400, "rst_col_next");

    for (int n = 0; n < 1000; n++) begin
      b = rand_blk();
      run_block(b, ($urandom_range(7) == 0) ? 2 : 0, 1'(($urandom_range(3) == 0) ? 1 : 0),
                ref_satd(b), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hadamard_satd_8x8.md
# hadamard_satd_8x8

Downstream consumer of the row-difference stage in the SATD datapath. Accepts one 8×8 block of signed ORG−CUR differences as 8 rows of 8 lanes. Applies an 8-point Hadamard transform to each row on entry, stores the results in a transpose buffer, then transforms the columns. Accumulates the absolute values of all 64 coefficients and emits one raw (unscaled) SATD per block.

## Interface
- DIFF_W, 9: signed width of each input difference.
- ROW_W, 12: signed width of row-transform coefficients (DIFF_W+3).
- COL_W, 15: signed width of column-transform coefficients (ROW_W+3).
- SATD_W, 20: unsigned width of the SATD result.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  diff_row holds a valid row.
- in_ready  out  1  block can accept a row this cycle.
- diff_row  in  8*DIFF_W  8 signed differences; lane 0 in bits [DIFF_W-1:0], lane k at [k*DIFF_W +: DIFF_W].
- out_valid  out  1  one-cycle pulse; out_satd is valid.
- out_satd  out  SATD_W  sum of |coefficient| over the 64 coefficients of the last block.

## Operation
- Row accept: a row is taken when in_valid && in_ready. Rows arrive in order 0..7. Gaps in in_valid are allowed and do not advance the row counter.
- State ROW (reset state), in_ready=1:
  - each accepted row passes through the combinational hadamard8 transform (Sylvester natural order, coefficients ±1, no scaling);
  - the 8 ROW_W results are written into transpose-buffer row r;
  - r (3-bit) increments. On accepting row 7, go to COL.
- State COL, in_ready=0 (in_valid is ignored). One column c=0..7 per cycle:
  - buffer column c (8 ROW_W values) passes through hadamard8 to give 8 COL_W coefficients;
  - take the absolute value of each coefficient and sum the 8;
  - add the sum into the accumulator.
  - After c=7, go to DONE.
- State DONE, in_ready=0:
  - out_satd is loaded from the accumulator; out_valid=1 for exactly this cycle;
  - the accumulator is cleared; next state is ROW.
- Arithmetic:
  - all butterflies are sign-extended, never saturated;
  - |x| is computed on COL_W bits (−2^(COL_W−1) cannot occur);
  - the accumulator is SATD_W wide and cannot overflow, since the maximum is 64·255·64 < 2^20.
- out_satd holds its value until the next DONE.
- Reset values: in_ready=1, out_valid=0, out_satd=0, state=ROW, r=0, c=0, accumulator=0. Transpose-buffer contents are don't-care.
- rst mid-block, in either ROW or COL: the partial block is discarded. The next accepted row is treated as row 0 of a new block. No out_valid is produced for the aborted block.

## Timing
- Row transform and buffer write occur at the accept edge; there is no pipeline stage on input.
- Latency: let E0 be the edge that accepts row 7.
  - COL accumulation happens at edges E1..E8.
  - DONE is the cycle after E8; out_valid is high between E9 and E10.
  - in_ready returns high at E9, so the next block's row 0 can be accepted at edge E10.
- Throughput: 8 rows + 8 columns + 1 done cycle = 17 cycles per block minimum.
- No output backpressure: the consumer must sample out_satd when out_valid is high.

## Structure
- Package satd_pkg holds:
  - DIFF_W, ROW_W, COL_W, SATD_W constants;
  - state enum {ROW, COL, DONE};
  - lane-slice helper for the diff_row packing (shared with the difference stage).
- Sub-module hadamard8:
  - combinational 8-point butterfly, 3 stages, parameterized input width IW, output width IW+3;
  - instantiated twice: row transform on diff_row, column transform on a buffer column.
- Transpose buffer: 8×8 ROW_W registers in the top module, written by row, read by column via mux on c.

## Test plan
- All differences 0 for 8 rows -> out_satd=0, out_valid pulses once at E9.
- All differences +1 -> only the DC coefficient is 64 -> out_satd=64.
- diff[0][0]=−255, all others 0 -> all 64 coefficients have magnitude 255 -> out_satd=16320. All differences +255 -> out_satd=16320.
- Checkerboard, diff[r][c]=(−1)^(r+c)·100 -> one coefficient of magnitude 6400 -> out_satd=6400.
- Flow control:
  - drive in_valid with random gaps, and hold in_valid high during COL/DONE with junk data;
  - required: junk is not accepted, in_ready=0 for exactly 9 cycles after row 7, and the result matches the all-+1 value of 64.
- Reset and random blocks:
  - assert rst after 4 rows of block A, then send full block B -> a single out_valid carrying B's SATD;
  - then 1000 random blocks with differences in [−255,255], checked against a reference model.
